// File: rtl/sobel_stream_edge.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, thresholded binary edge map out.
// Latency: 2 enabled cycles from accepted qualifying pixel to m_valid; 1 pixel/clk sustained.
// Backpressure: whole pipeline freezes while m_valid && !m_ready; s_ready mirrors that enable.
// Optional feature: define SOBEL_MAG_OUT_EN to expose the unthresholded magnitude on m_mag.
module sobel_stream_edge #(
    parameter int  PIX_W = 8,
    parameter int  IMG_W = 640,
    parameter int  IMG_H = 480,
    localparam int MAG_W = PIX_W + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [PIX_W-1:0] s_pix,
    input  logic [MAG_W-1:0] threshold,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sof,
    output logic             m_eol,
    output logic [PIX_W-1:0] m_edge
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [MAG_W-1:0] m_mag
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Flow control
    logic en;
    logic accept;

    // Position of the current beat and the position of the next one
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    // Frame threshold
    logic [MAG_W-1:0] thr_q, thr_cur;

    // Line buffers (row-1 and row-2) and the two older window columns
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] lb2_q [IMG_W];
    logic [PIX_W-1:0] win_c0_q [3];   // column col-2: top, mid, bottom
    logic [PIX_W-1:0] win_c1_q [3];   // column col-1: top, mid, bottom
    logic [PIX_W-1:0] col_top, col_mid;

    // Gradient arithmetic
    logic signed [MAG_W-1:0] p00, p10, p20, p01, p21, p02, p12, p22;
    logic signed [MAG_W-1:0] gx_d, gy_d;

    // Stage 1 registers
    logic                    v1_q, sof1_q, eol1_q;
    logic signed [MAG_W-1:0] gx_q, gy_q;
    logic [MAG_W-1:0]        thr1_q;

    // Stage 2 (output) registers
    logic [MAG_W-1:0] gx_abs, gy_abs, mag;
    logic             m_valid_q, m_sof_q, m_eol_q;
    logic [PIX_W-1:0] m_edge_q;
    logic [MAG_W-1:0] m_mag_q;

    assign en      = !(m_valid_q && !m_ready);
    assign s_ready = en;
    assign accept  = s_valid && en;

    // A start-of-frame beat is always treated as (0,0), discarding any partial frame
    assign cur_col = s_sof ? '0 : col_q;
    assign cur_row = s_sof ? '0 : row_q;
    assign thr_cur = s_sof ? threshold : thr_q;

    // Raster position of the beat that follows the current one
    always_comb begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
        if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end
    end

    // Column/row counters and per-frame threshold latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            thr_q <= '0;
        end else if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            if (s_sof) begin
                thr_q <= threshold;
            end
        end
    end

    assign col_top = lb2_q[cur_col];
    assign col_mid = lb1_q[cur_col];

    // Line buffers shift down one row per column; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= s_pix;
            lb2_q[cur_col] <= lb1_q[cur_col];
        end
    end

    // Window shift: the two previous columns of the current row band
    always_ff @(posedge clk) begin
        if (accept) begin
            win_c0_q <= win_c1_q;
            win_c1_q <= '{col_top, col_mid, s_pix};
        end
    end

    // Zero-extended window taps; pRC = row R (0 = top), column C (0 = left)
    assign p00 = $signed({{(MAG_W-PIX_W){1'b0}}, win_c0_q[0]});
    assign p10 = $signed({{(MAG_W-PIX_W){1'b0}}, win_c0_q[1]});
    assign p20 = $signed({{(MAG_W-PIX_W){1'b0}}, win_c0_q[2]});
    assign p01 = $signed({{(MAG_W-PIX_W){1'b0}}, win_c1_q[0]});
    assign p21 = $signed({{(MAG_W-PIX_W){1'b0}}, win_c1_q[2]});
    assign p02 = $signed({{(MAG_W-PIX_W){1'b0}}, col_top});
    assign p12 = $signed({{(MAG_W-PIX_W){1'b0}}, col_mid});
    assign p22 = $signed({{(MAG_W-PIX_W){1'b0}}, s_pix});

    assign gx_d = (p02 + p12 + p12 + p22) - (p00 + p10 + p10 + p20);
    assign gy_d = (p20 + p21 + p21 + p22) - (p00 + p01 + p01 + p02);

    // Stage 1: register gradients; only full windows (row>=2, col>=2) become valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
            thr1_q <= '0;
        end else if (en) begin
            v1_q   <= accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            sof1_q <= (cur_row == ROW_TWO) && (cur_col == COL_TWO);
            eol1_q <= (cur_col == COL_LAST);
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            // Threshold travels with the pixel so frame boundaries never mix thresholds
            thr1_q <= thr_cur;
        end
    end

    assign gx_abs = gx_q[MAG_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    assign gy_abs = gy_q[MAG_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    assign mag    = gx_abs + gy_abs;

    // Stage 2: magnitude compare into the output register; markers are gated by valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_edge_q  <= '0;
            m_mag_q   <= '0;
        end else if (en) begin
            m_valid_q <= v1_q;
            m_sof_q   <= v1_q && sof1_q;
            m_eol_q   <= v1_q && eol1_q;
            m_edge_q  <= (v1_q && (mag > thr1_q)) ? '1 : '0;
            m_mag_q   <= v1_q ? mag : '0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;
    assign m_edge  = m_edge_q;

`ifdef SOBEL_MAG_OUT_EN
    assign m_mag = m_mag_q;
`else
    logic unused_mag;
    assign unused_mag = ^m_mag_q;
`endif

endmodule

// File: tb/tb_sobel_stream_edge.sv
// Bench for sobel_stream_edge on an 8x6 image: reference model of the Sobel rules plus literal pins.
// Drives frames with optional random input gaps and random output backpressure.
// Build with SOBEL_MAG_OUT_EN defined to also check the magnitude output.
module tb_sobel_stream_edge;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int MAG_W = PIX_W + 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic             s_sof;
    logic [PIX_W-1:0] s_pix;
    logic [MAG_W-1:0] threshold;
    logic             m_valid;
    logic             m_ready;
    logic             m_sof;
    logic             m_eol;
    logic [PIX_W-1:0] m_edge;
`ifdef SOBEL_MAG_OUT_EN
    logic [MAG_W-1:0] m_mag;
`endif

    always #5 clk = ~clk;

    sobel_stream_edge #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_pix(s_pix),
        .threshold(threshold),
        .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
        .m_edge(m_edge)
`ifdef SOBEL_MAG_OUT_EN
        , .m_mag(m_mag)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int bp_mode  = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int edg;
        int sof;
        int eol;
        int mag;
    } exp_t;

    exp_t exp_q[$];
    int   img [IMG_H][IMG_W];
    int   mrow = 0, mcol = 0, mthr = 0;
    int   out_cnt = 0, edge_cnt = 0;
    int   obs_edge[$], obs_sof[$], obs_eol[$], obs_mag[$];

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_accept(int sof, int pix, int thr);
        int r, c, gx, gy, mg;
        exp_t e;
        r = sof ? 0 : mrow;
        c = sof ? 0 : mcol;
        if (sof) mthr = thr;
        img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
            mg = iabs(gx) + iabs(gy);
            e.edg = (mg > mthr) ? 255 : 0;
            e.sof = (r == 2 && c == 2) ? 1 : 0;
            e.eol = (c == IMG_W - 1) ? 1 : 0;
            e.mag = mg;
            exp_q.push_back(e);
        end
        if (c == IMG_W - 1) begin
            mcol = 0;
            mrow = (r == IMG_H - 1) ? 0 : r + 1;
        end else begin
            mcol = c + 1;
            mrow = r;
        end
    endfunction

    // Single compare process: samples at the falling edge, between active edges
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            mrow = 0;
            mcol = 0;
            mthr = 0;
        end else begin
            check("s_ready_rule", int'(s_ready), int'(!(m_valid && !m_ready)));
            if (!m_valid) check("idle_markers", int'({m_sof, m_eol}), 0);
            if (s_valid && s_ready) model_accept(int'(s_sof), int'(s_pix), int'(threshold));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_edge", int'(m_edge), e.edg);
                    check("m_sof", int'(m_sof), e.sof);
                    check("m_eol", int'(m_eol), e.eol);
`ifdef SOBEL_MAG_OUT_EN
                    check("m_mag", int'(m_mag), e.mag);
                    obs_mag.push_back(int'(m_mag));
`endif
                end
                out_cnt++;
                if (m_edge != 0) edge_cnt++;
                obs_edge.push_back(int'(m_edge));
                obs_sof.push_back(int'(m_sof));
                obs_eol.push_back(int'(m_eol));
            end
        end
    end

    // Output-side ready: always 1, or a fair coin when backpressure is enabled
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    function automatic int pix_at(int mode, int r, int c);
        case (mode)
            0: return 100;
            1: return (c >= 4) ? 255 : 0;
            2: return (r == 2 && c == 3) ? 255 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic clear_stats();
        out_cnt  = 0;
        edge_cnt = 0;
        obs_edge.delete();
        obs_sof.delete();
        obs_eol.delete();
        obs_mag.delete();
    endtask

    // Sends npix raster pixels starting with s_sof; threshold switches to thr_after once sof is taken
    task automatic send_frame(int mode, int thr, int thr_after, int npix, int gaps);
        bit acc;
        int tmo;
        for (int k = 0; k < npix; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid   = 1'b1;
            s_sof     = (k == 0);
            s_pix     = PIX_W'(pix_at(mode, k / IMG_W, k % IMG_W));
            threshold = (k == 0) ? MAG_W'(thr) : MAG_W'(thr_after);
            tmo = 0;
            acc = 1'b0;
            while (!acc && tmo < 1000) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                tmo++;
            end
            if (!acc) check("send_timeout", 1, 0);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_step_pattern(string tag);
        for (int i = 0; i < 24 && i < obs_edge.size(); i++) begin
            check({tag, "_edge_lit"}, obs_edge[i], ((i % 6) == 2 || (i % 6) == 3) ? 255 : 0);
`ifdef SOBEL_MAG_OUT_EN
            check({tag, "_mag_lit"}, obs_mag[i], ((i % 6) == 2 || (i % 6) == 3) ? 1020 : 0);
`endif
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_sof     = 1'b0;
        s_pix     = '0;
        threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_sof", int'(m_sof), 0);
        check("rst_m_eol", int'(m_eol), 0);
        check("rst_m_edge", int'(m_edge), 0);
        check("rst_s_ready", int'(s_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Flat frame
        clear_stats();
        send_frame(0, 254, 254, IMG_W * IMG_H, 0);
        drain();
        check("flat_count", out_cnt, 24);
        check("flat_edges", edge_cnt, 0);
        for (int i = 0; i < 24 && i < obs_sof.size(); i++) begin
            check("flat_sof_lit", obs_sof[i], (i == 0) ? 1 : 0);
            check("flat_eol_lit", obs_eol[i], ((i % 6) == 5) ? 1 : 0);
        end

        // Vertical step
        clear_stats();
        send_frame(1, 254, 254, IMG_W * IMG_H, 0);
        drain();
        check("step_count", out_cnt, 24);
        check("step_edges", edge_cnt, 8);
        check_step_pattern("step");

        // Threshold boundary around magnitude 510, and mid-frame threshold changes
        clear_stats();
        send_frame(2, 510, 510, IMG_W * IMG_H, 0);
        drain();
        check("thr510_edges", edge_cnt, 0);
        clear_stats();
        send_frame(2, 509, 2000, IMG_W * IMG_H, 0);
        drain();
        check("thr509_edges", edge_cnt, 8);
        clear_stats();
        send_frame(2, 510, 0, IMG_W * IMG_H, 0);
        drain();
        check("thr_midframe_edges", edge_cnt, 0);

        // Backpressure and input gaps on the step frame
        bp_mode = 1;
        clear_stats();
        send_frame(1, 254, 254, IMG_W * IMG_H, 1);
        drain();
        check("bp_count", out_cnt, 24);
        check("bp_edges", edge_cnt, 8);
        check_step_pattern("bp");

        // Random pixels and thresholds under backpressure
        for (int f = 0; f < 4; f++) begin
            send_frame(3, int'($urandom_range(0, 1500)), int'($urandom_range(0, 2047)),
                       IMG_W * IMG_H, 1);
        end
        drain();
        bp_mode = 0;

        // Resync: sof at row 3, col 5 of a partial step frame, then a full frame
        clear_stats();
        send_frame(1, 254, 254, 3 * IMG_W + 5, 0);
        send_frame(1, 254, 254, IMG_W * IMG_H, 0);
        drain();
        check("resync_count", out_cnt, 9 + 24);
        check("resync_edges", edge_cnt, 3 + 8);

        // Reset mid-frame while outputs are in flight
        send_frame(0, 0, 0, 30, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_s_ready", int'(s_ready), 1);
        rst_n = 1'b1;
        clear_stats();
        send_frame(1, 254, 254, IMG_W * IMG_H, 0);
        drain();
        check("postrst_count", out_cnt, 24);
        check("postrst_edges", edge_cnt, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
